// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared types for the multiply/divide unit.
//   md_op_e    : 3-bit operation code carried on op.
//   md_state_e : sequencing FSM states.
//   md_op_legal / md_op_is_div : decode helpers.
// Optional feature: MD_MADD_EN makes MADD/MADDU legal operations;
// without it those codes decode as reserved.
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MADD  = 3'b100,
        MD_MADDU = 3'b101,
        MD_RSV6  = 3'b110,
        MD_RSV7  = 3'b111
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    function automatic logic md_op_legal(input logic [2:0] op);
        logic ok;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: ok = 1'b1;
`ifdef MD_MADD_EN
            MD_MADD, MD_MADDU:                  ok = 1'b1;
`else
            MD_MADD, MD_MADDU:                  ok = 1'b0;
`endif
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic md_op_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: EX-stage handshake bundle for the multiply/divide unit.
//   start/op/A/B : operation launch and forwarded RS/RT operands
//   hi_wr/lo_wr/WD : MTHI/MTLO strobes and data
//   busy/HI/LO   : status and registered HI/LO results
// master = EX control side (drives requests), slave = muldiv_unit.
interface muldiv_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hi_wr;
    logic        lo_wr;
    logic [31:0] WD;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, op, A, B, hi_wr, lo_wr, WD,
        input  busy, HI, LO
    );

    modport slave (
        input  start, op, A, B, hi_wr, lo_wr, WD,
        output busy, HI, LO
    );
endinterface

// File: rtl/muldiv_calc.sv
// muldiv_calc: combinational result generator for the multiply/divide unit.
//   op, a, b : latched operation and operands
//   hi, lo   : current HI/LO (returned unchanged when nothing is written)
//   hi_nxt, lo_nxt : proposed HI/LO values
//   we       : result write enable; 0 on divide-by-zero and reserved ops
// Optional feature: MD_MADD_EN builds the 64-bit accumulate path.
module muldiv_calc
    import muldiv_unit_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] hi_nxt,
    output logic [31:0] lo_nxt,
    output logic        we
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        sdiv;
    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic [31:0] dvs_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'b0, a} * {32'b0, b};

    // Signed division runs on magnitudes and re-applies the signs, which
    // makes 0x80000000 / -1 fall out naturally as LO=0x80000000, HI=0.
    assign sdiv     = (op == MD_DIV);
    assign dvd_mag  = (sdiv && a[31]) ? (~a + 32'd1) : a;
    assign dvs_mag  = (sdiv && b[31]) ? (~b + 32'd1) : b;
    assign dvs_safe = (dvs_mag == '0) ? 32'd1 : dvs_mag;
    assign q_mag    = dvd_mag / dvs_safe;
    assign r_mag    = dvd_mag % dvs_safe;
    assign quot     = (sdiv && (a[31] ^ b[31])) ? (~q_mag + 32'd1) : q_mag;
    assign rem      = (sdiv && a[31]) ? (~r_mag + 32'd1) : r_mag;

`ifdef MD_MADD_EN
    logic [63:0] acc_s;
    logic [63:0] acc_u;
    assign acc_s = {hi, lo} + prod_s;
    assign acc_u = {hi, lo} + prod_u;
`endif

    always_comb begin
        hi_nxt = hi;
        lo_nxt = lo;
        we     = 1'b0;
        case (op)
            MD_MULT: begin
                {hi_nxt, lo_nxt} = prod_s;
                we = 1'b1;
            end
            MD_MULTU: begin
                {hi_nxt, lo_nxt} = prod_u;
                we = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
                if (b != '0) begin
                    hi_nxt = rem;
                    lo_nxt = quot;
                    we     = 1'b1;
                end
            end
`ifdef MD_MADD_EN
            MD_MADD: begin
                {hi_nxt, lo_nxt} = acc_s;
                we = 1'b1;
            end
            MD_MADDU: begin
                {hi_nxt, lo_nxt} = acc_u;
                we = 1'b1;
            end
`endif
            default: begin
                we = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit with HI/LO registers.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (aborts any operation in flight)
//   bus  : muldiv_unit_if.slave -- start/op/A/B launch, hi_wr/lo_wr/WD
//          MTHI/MTLO, busy/HI/LO outputs (all registered)
// Parameters: MUL_CYCLES (1..15) and DIV_CYCLES (1..15) busy cycles.
// Optional feature: MD_MADD_EN enables MADD/MADDU (ops 100/101);
// otherwise those codes are ignored like the reserved ones.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input logic           clk,
    input logic           rst,
    muldiv_unit_if.slave  bus
);

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES);

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [31:0] a_q,     a_d;
    logic [31:0] b_q,     b_d;
    md_op_e      op_q,    op_d;
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;

    logic [31:0] calc_hi;
    logic [31:0] calc_lo;
    logic        calc_we;

    muldiv_calc u_calc (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .hi     (hi_q),
        .lo     (lo_q),
        .hi_nxt (calc_hi),
        .lo_nxt (calc_lo),
        .we     (calc_we)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            MD_IDLE: begin
                if (bus.start) begin
                    // start takes priority: MTHI/MTLO strobes in the same
                    // cycle are dropped even if op turns out to be reserved.
                    if (md_op_legal(bus.op)) begin
                        a_d     = bus.A;
                        b_d     = bus.B;
                        op_d    = md_op_e'(bus.op);
                        cnt_d   = md_op_is_div(bus.op) ? DIV_LOAD : MUL_LOAD;
                        state_d = MD_RUN;
                    end
                end else begin
                    if (bus.hi_wr) hi_d = bus.WD;
                    if (bus.lo_wr) lo_d = bus.WD;
                end
            end
            MD_RUN: begin
                // Counter is loaded with N at the start edge and seen as 1
                // at the Nth following edge, which is the completion edge.
                if (cnt_q == 4'd1) begin
                    if (calc_we) begin
                        hi_d = calc_hi;
                        lo_d = calc_lo;
                    end
                    cnt_d   = '0;
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= MD_MULT;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy = (state_q == MD_RUN);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule
